// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin sharing of one register bus among several masters, with a completion watchdog
module bus_master_arbiter #(
  parameter int                      NumMasters    = 2,
  parameter int                      AddressWidth  = 32,
  parameter int                      DataWidth     = 32,
  parameter logic [AddressWidth-1:0] IdleAddress   = 32'hFFFF_FFFF,
  parameter int                      TimeoutCycles = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NumMasters-1:0]             req_i,
  input  logic [NumMasters-1:0]             we_i,
  input  logic [4*NumMasters-1:0]           we_ram_i,
  input  logic [AddressWidth*NumMasters-1:0] address_i,
  input  logic [DataWidth*NumMasters-1:0]   data_i,
  output logic [NumMasters-1:0]             ack_o,
  output logic                              err_o,
  output logic [DataWidth-1:0]              rdata_o,
  output logic [NumMasters-1:0]             grant_o,
  output logic                              bus_we_o,
  output logic [3:0]                        bus_we_ram_o,
  output logic [AddressWidth-1:0]           bus_address_o,
  output logic [DataWidth-1:0]              bus_data_o,
  input  logic [DataWidth-1:0]              bus_rdata_i,
  input  logic                              bus_busy_i
);
  localparam int IW = $clog2(NumMasters);
  localparam int CW = $clog2(TimeoutCycles);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_t;
  state_t                  r_state, w_state_n;
  logic [IW-1:0]           r_last, w_last_n, w_idx, w_cand;
  logic                    w_found;
  logic [CW-1:0]           r_cnt, w_cnt_n;
  logic [NumMasters-1:0]   r_ack, w_ack_n, r_grant, w_grant_n;
  logic                    r_err, w_err_n, r_bus_we, w_bus_we_n;
  logic [DataWidth-1:0]    r_rdata, w_rdata_n, r_bus_data, w_bus_data_n;
  logic [3:0]              r_bus_we_ram, w_bus_we_ram_n;
  logic [AddressWidth-1:0] r_bus_addr, w_bus_addr_n;
  // Pick the first requester after the previous owner, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_idx = r_last;
    w_cand = '0;
    for (int k = 1; k <= NumMasters; k++) begin
      w_cand = IW'((int'(r_last) + k) % NumMasters);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_idx = w_cand;
      end
    end
  end
  // Next state and next values of every registered output
  always_comb begin
    w_state_n = r_state;
    w_last_n = r_last;
    w_cnt_n = r_cnt;
    w_ack_n = r_ack;
    w_err_n = r_err;
    w_rdata_n = r_rdata;
    w_grant_n = r_grant;
    w_bus_we_n = 1'b0;
    w_bus_we_ram_n = 4'h0;
    w_bus_addr_n = IdleAddress;
    w_bus_data_n = '0;
    case (r_state)
      S_IDLE: if (w_found) begin
        w_state_n = S_ISSUE;
        w_last_n = w_idx;
        w_grant_n = NumMasters'(1) << w_idx;
        w_bus_we_n = we_i[w_idx];
        w_bus_we_ram_n = we_ram_i[4*w_idx +: 4];
        w_bus_addr_n = address_i[AddressWidth*w_idx +: AddressWidth];
        w_bus_data_n = data_i[DataWidth*w_idx +: DataWidth];
      end
      S_ISSUE: w_state_n = S_GUARD;
      // bus_cdc raises busy one cycle late, so it is not looked at here
      S_GUARD: w_state_n = S_WAIT;
      S_WAIT: if (!bus_busy_i || r_cnt == CW'(TimeoutCycles - 1)) begin
        w_state_n = S_RESP;
        w_ack_n = r_grant;
        w_err_n = bus_busy_i;
        w_rdata_n = bus_busy_i ? '0 : bus_rdata_i;
      end else begin
        w_cnt_n = r_cnt + CW'(1);
      end
      S_RESP: begin
        w_state_n = S_IDLE;
        w_ack_n = '0;
        w_grant_n = '0;
        w_cnt_n = '0;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  // State and output registers; the bus idles on IdleAddress so repeats look like address changes
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= S_IDLE;
      r_last <= IW'(NumMasters - 1);
      r_cnt <= '0;
      r_ack <= '0;
      r_err <= 1'b0;
      r_rdata <= '0;
      r_grant <= '0;
      r_bus_we <= 1'b0;
      r_bus_we_ram <= 4'h0;
      r_bus_addr <= IdleAddress;
      r_bus_data <= '0;
    end else begin
      r_state <= w_state_n;
      r_last <= w_last_n;
      r_cnt <= w_cnt_n;
      r_ack <= w_ack_n;
      r_err <= w_err_n;
      r_rdata <= w_rdata_n;
      r_grant <= w_grant_n;
      r_bus_we <= w_bus_we_n;
      r_bus_we_ram <= w_bus_we_ram_n;
      r_bus_addr <= w_bus_addr_n;
      r_bus_data <= w_bus_data_n;
    end
  assign ack_o = r_ack;
  assign err_o = r_err;
  assign rdata_o = r_rdata;
  assign grant_o = r_grant;
  assign bus_we_o = r_bus_we;
  assign bus_we_ram_o = r_bus_we_ram;
  assign bus_address_o = r_bus_addr;
  assign bus_data_o = r_bus_data;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: randomized scoreboard bench with a transaction-level arbitration model
module tb_bus_master_arbiter;
  localparam int N = 3;
  localparam int T = 16;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
  typedef struct {
    int          m;
    logic        we;
    logic [3:0]  wr;
    logic [31:0] a;
    logic [31:0] d;
    int          b;
    logic [31:0] v;
  } txn_t;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [N-1:0] req = '0, we = '0, ack_o, grant_o;
  logic [4*N-1:0] we_ram = '0;
  logic [32*N-1:0] addr = '0, data = '0;
  logic err_o, bus_we_o, bus_busy_i;
  logic [31:0] rdata_o, bus_address_o, bus_data_o, bus_rdata_i;
  logic [3:0] bus_we_ram_o;
  int checks = 0, failures = 0;
  int last = N - 1;
  txn_t eq[$], rq[$], dq[$];
  txn_t cq[N][$];

  bus_master_arbiter #(.NumMasters(N), .AddressWidth(32), .DataWidth(32),
    .IdleAddress(IDLE), .TimeoutCycles(T)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req), .we_i(we), .we_ram_i(we_ram),
    .address_i(addr), .data_i(data), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .grant_o(grant_o), .bus_we_o(bus_we_o), .bus_we_ram_o(bus_we_ram_o),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o),
    .bus_rdata_i(bus_rdata_i), .bus_busy_i(bus_busy_i));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic txn_t mk(logic w, logic [3:0] r, logic [31:0] a, logic [31:0] d, int b, logic [31:0] v);
    txn_t t;
    t.m = 0; t.we = w; t.wr = r; t.a = a; t.d = d; t.b = b; t.v = v;
    return t;
  endfunction

  function automatic txn_t rnd();
    int b;
    b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T - 1)) : int'($urandom_range(0, 5));
    return mk(1'($urandom), 4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, b, $urandom);
  endfunction

  task automatic drive(input int m, input txn_t t);
    we[m] = t.we;
    we_ram[4*m +: 4] = t.wr;
    addr[32*m +: 32] = t.a;
    data[32*m +: 32] = t.d;
  endtask

  task automatic check_reset(input string n);
    chk({n, "_ack"}, 32'(ack_o), 0);
    chk({n, "_err"}, 32'(err_o), 0);
    chk({n, "_grant"}, 32'(grant_o), 0);
    chk({n, "_rdata"}, rdata_o, 0);
    chk({n, "_bus_we"}, 32'(bus_we_o), 0);
    chk({n, "_bus_we_ram"}, 32'(bus_we_ram_o), 0);
    chk({n, "_bus_data"}, bus_data_o, 0);
    chk({n, "_bus_addr"}, bus_address_o, IDLE);
  endtask

  // Model: every master in mask keeps requesting for `rounds` transactions, so owners
  // follow the rotation starting after the previous owner, repeated once per round.
  task automatic run_batch(input logic [N-1:0] mask, input int rounds);
    int order[$];
    int pending, budget;
    txn_t t;
    for (int r = 0; r < rounds; r++)
      for (int k = 1; k <= N; k++)
        if (mask[(last + k) % N]) order.push_back((last + k) % N);
    if (order.size() > 0) last = order[order.size() - 1];
    foreach (order[i]) begin
      t = (dq.size() > 0) ? dq.pop_front() : rnd();
      t.m = order[i];
      eq.push_back(t);
      rq.push_back(t);
      cq[t.m].push_back(t);
    end
    @(negedge clk);
    for (int m = 0; m < N; m++)
      if (cq[m].size() > 0) begin
        drive(m, cq[m][0]);
        req[m] = 1'b1;
      end
    pending = order.size();
    budget = pending * (T + 12) + 20;
    while (pending > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int m = 0; m < N; m++)
        if (ack_o[m] && cq[m].size() > 0) begin
          pending--;
          void'(cq[m].pop_front());
          if (cq[m].size() > 0) begin
            drive(m, cq[m][0]);
            req[m] = 1'b1;
          end else req[m] = 1'b0;
        end else if (grant_o[m] && bus_address_o != IDLE) begin
          drive(m, rnd());
          if ($urandom_range(0, 1) == 1) req[m] = 1'b0;
        end
    end
    chk("batch_complete_pending", 32'(pending), 0);
    if (pending != 0) finish_tb();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Bus side: busy rises right after the issue pulse, stays up b WAIT cycles, then
  // falls with read data valid for that single cycle only
  initial begin
    txn_t t;
    bus_busy_i = 1'b0;
    bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus_rdata_i = $urandom;
      if (reset_i) bus_busy_i = 1'b0;
      else if (bus_address_o != IDLE) begin
        t = (rq.size() > 0) ? rq.pop_front() : mk(0, 0, 0, 0, 0, 0);
        bus_busy_i = 1'b1;
        for (int k = 0; k < t.b + 2 && !reset_i; k++) begin
          @(negedge clk);
          bus_rdata_i = $urandom;
        end
        bus_busy_i = 1'b0;
        bus_rdata_i = t.v;
      end
    end
  end

  // Monitor: pops the expected command on each issue pulse and checks the response on ack
  initial begin
    int cyc = 0, issue_cyc = 0, last_issue = 0, lat;
    bit active = 0, have_last = 0, grant_bad = 0;
    logic [N-1:0] oh = '0;
    txn_t cur;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_i) begin
        active = 0;
        have_last = 0;
      end else begin
        if (bus_address_o != IDLE) begin
          if (have_last) chk("issue_gap_ge5", 32'(cyc - last_issue >= 5), 1);
          chk("issue_while_active", 32'(active), 0);
          chk("issue_expected", 32'(eq.size() > 0), 1);
          if (eq.size() > 0) begin
            cur = eq.pop_front();
            oh = N'(1) << cur.m;
            chk("issue_grant", 32'(grant_o), 32'(oh));
            chk("issue_we", 32'(bus_we_o), 32'(cur.we));
            chk("issue_we_ram", 32'(bus_we_ram_o), 32'(cur.wr));
            chk("issue_addr", bus_address_o, cur.a);
            chk("issue_data", bus_data_o, cur.d);
            active = 1;
            grant_bad = 0;
            issue_cyc = cyc;
          end
          last_issue = cyc;
          have_last = 1;
        end else begin
          chk("bus_idle_zero", {bus_data_o | 32'(bus_we_ram_o) | 32'(bus_we_o)}, 0);
        end
        if (active) grant_bad = grant_bad | (grant_o != oh);
        else chk("grant_idle", 32'(grant_o), 0);
        if (ack_o != '0) begin
          chk("ack_expected", 32'(active), 1);
          if (active) begin
            lat = (cur.b >= T) ? 2 + T : 3 + cur.b;
            chk("ack_onehot", 32'(ack_o), 32'(oh));
            chk("ack_err", 32'(err_o), 32'(cur.b >= T));
            chk("ack_rdata", rdata_o, (cur.b >= T) ? 32'h0 : cur.v);
            chk("ack_latency", 32'(cyc - issue_cyc), 32'(lat));
            chk("grant_held", 32'(grant_bad), 0);
            active = 0;
          end
        end else if (active && cyc - issue_cyc > T + 8) begin
          chk("ack_watchdog", 32'(cyc - issue_cyc), 32'(T + 2));
          active = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    failures++;
    finish_tb();
  end

  initial begin
    txn_t t;
    int w;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    // master 0 write, no busy
    dq.push_back(mk(1'b1, 4'hF, 32'h0000_9000, 32'h0000_1234, 0, $urandom));
    run_batch(3'b001, 1);
    // master 1 read with 10 busy WAIT cycles
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9004, $urandom, 10, 32'hCAFE_F00D));
    run_batch(3'b010, 1);
    // masters 0 and 1 continuously: 0,1,0,1,0,1
    run_batch(3'b011, 3);
    // two reads of the same address by master 0
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9000, 0, 0, $urandom));
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9000, 0, 1, $urandom));
    run_batch(3'b001, 2);
    // watchdog: busy outlives the timeout, its late fall must not produce an ack
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9010, 0, T + 3, $urandom));
    run_batch(3'b001, 1);
    repeat (12) @(negedge clk);
    // completion on the last WAIT cycle, then exact timeout
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9020, 0, T - 1, $urandom));
    dq.push_back(mk(1'b0, 4'h0, 32'h0000_9024, 0, T, $urandom));
    run_batch(3'b110, 1);
    repeat (4) @(negedge clk);
    // random traffic
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(1, (1 << N) - 1);
      run_batch(N'(w), $urandom_range(1, 3));
    end
    // reset while in WAIT, then arbitration restarts from master 0
    t = mk(1'b0, 4'h0, 32'h0000_9008, 0, 12, 32'h55);
    eq.push_back(t);
    rq.push_back(t);
    drive(0, t);
    @(negedge clk);
    req[0] = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus_address_o == IDLE && w < 20);
    chk("reset_test_issue_seen", 32'(w < 20), 1);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset_i = 1'b1;
    #1 check_reset("mid");
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_ack", 32'(ack_o), 0);
    end
    reset_i = 1'b0;
    last = N - 1;
    eq.delete();
    rq.delete();
    for (int m = 0; m < N; m++) cq[m].delete();
    run_batch(3'b011, 1);
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(eq.size()), 0);
    finish_tb();
  end
endmodule
